// File: rtl/sorter_gate_ctrl_pkg.sv
// ============================================================================
// Module : sorter_gate_ctrl_pkg
// Brief  : Grade codes, gate FSM states and helpers shared by the bean sorter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sorter_gate_ctrl_pkg;

  // Grade codes shared with the upstream classifier FSMs.
  localparam logic [1:0] GRADE_BAJA    = 2'd0;
  localparam logic [1:0] GRADE_MEDIA   = 2'd1;
  localparam logic [1:0] GRADE_ALTA    = 2'd2;
  localparam logic [1:0] GRADE_RECHAZO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } gate_state_t;

  // Bit order {rechazo, alta, media, baja} matches the grade code.
  function automatic logic [3:0] grade_onehot(input logic [1:0] g);
    return 4'b0001 << g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sorter_fifo.sv
// ============================================================================
// Module : sorter_fifo
// Brief  : Synchronous FIFO holding {grade, timestamp} for beans in transit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sorter_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [c_PTR_W:0] r_wr_ptr;
  logic [c_PTR_W:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr[c_PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/sorter_gate_ctrl.sv
// ============================================================================
// Module : sorter_gate_ctrl
// Brief  : Buffers bean grades over the conveyor travel time, then pulses the
//          matching diverter gate and keeps saturating per-grade counts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sorter_gate_ctrl
  import sorter_gate_ctrl_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int TS_W          = 16,
  parameter int TRAVEL_CYCLES = 20,
  parameter int PULSE_CYCLES  = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grade_valid,
  input  logic [1:0]       grade,
  output logic             grade_ready,
  output logic             gate_baja,
  output logic             gate_media,
  output logic             gate_alta,
  output logic             gate_rechazo,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] cnt_baja,
  output logic [CNT_W-1:0] cnt_media,
  output logic [CNT_W-1:0] cnt_alta
);

  localparam int c_FIFO_W  = 2 + TS_W;
  localparam int c_TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX) + 1;

  gate_state_t         r_state;
  gate_state_t         w_state_nxt;
  logic [c_TMR_W-1:0]  r_tmr;
  logic [c_TMR_W-1:0]  w_tmr_nxt;
  logic [3:0]          r_gate;
  logic [3:0]          w_gate_nxt;
  logic [TS_W-1:0]     r_ts;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_cnt_baja;
  logic [CNT_W-1:0]    r_cnt_media;
  logic [CNT_W-1:0]    r_cnt_alta;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [c_FIFO_W-1:0] w_head;
  logic [1:0]          w_head_grade;
  logic [TS_W-1:0]     w_head_stamp;
  logic [TS_W-1:0]     w_age;
  logic                w_head_due;

  assign grade_ready  = !w_full;
  assign w_push       = grade_valid && !w_full;
  assign w_head_grade = w_head[c_FIFO_W-1 -: 2];
  assign w_head_stamp = w_head[TS_W-1:0];
  // Modular age keeps the due test correct across timestamp wrap.
  assign w_age        = r_ts - w_head_stamp;
  assign w_head_due   = (w_age >= TS_W'(TRAVEL_CYCLES));

  sorter_fifo #(
    .WIDTH (c_FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({grade, r_ts}),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_gate  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_gate  <= w_gate_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + c_TMR_W'(1);
    w_gate_nxt  = r_gate;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt = '0;
        if (!w_empty && w_head_due) begin
          w_pop       = 1'b1;
          w_gate_nxt  = grade_onehot(w_head_grade);
          w_state_nxt = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (r_tmr == c_TMR_W'(PULSE_CYCLES - 1)) begin
          w_tmr_nxt   = '0;
          w_gate_nxt  = '0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_tmr == c_TMR_W'(GAP_CYCLES - 1)) begin
          w_tmr_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_tmr_nxt   = '0;
        w_gate_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts        <= '0;
      r_overflow  <= 1'b0;
      r_cnt_baja  <= '0;
      r_cnt_media <= '0;
      r_cnt_alta  <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (grade_valid && w_full) r_overflow <= 1'b1;
      // Rejected beans are diverted but never counted.
      if (w_pop) begin
        case (w_head_grade)
          GRADE_BAJA:  if (r_cnt_baja  != '1) r_cnt_baja  <= r_cnt_baja  + CNT_W'(1);
          GRADE_MEDIA: if (r_cnt_media != '1) r_cnt_media <= r_cnt_media + CNT_W'(1);
          GRADE_ALTA:  if (r_cnt_alta  != '1) r_cnt_alta  <= r_cnt_alta  + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign gate_baja    = r_gate[GRADE_BAJA];
  assign gate_media   = r_gate[GRADE_MEDIA];
  assign gate_alta    = r_gate[GRADE_ALTA];
  assign gate_rechazo = r_gate[GRADE_RECHAZO];
  assign busy         = !w_empty || (r_state != ST_IDLE);
  assign overflow     = r_overflow;
  assign cnt_baja     = r_cnt_baja;
  assign cnt_media    = r_cnt_media;
  assign cnt_alta     = r_cnt_alta;

endmodule

`default_nettype wire

// File: tb/tb_sorter_gate_ctrl.sv
// ============================================================================
// Module : tb_sorter_gate_ctrl
// Brief  : Directed and random stimulus checked against a bean-schedule model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sorter_gate_ctrl;

  // Narrow timestamp exercises wrap; narrow counters exercise saturation.
  localparam int DEPTH  = 4;
  localparam int TS_W   = 8;
  localparam int TRAVEL = 20;
  localparam int PULSE  = 4;
  localparam int GAP    = 2;
  localparam int CNT_W  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             grade_valid;
  logic [1:0]       grade;
  logic             grade_ready;
  logic             gate_baja, gate_media, gate_alta, gate_rechazo;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] cnt_baja, cnt_media, cnt_alta;

  always #5 clk = ~clk;

  sorter_gate_ctrl #(
    .DEPTH         (DEPTH),
    .TS_W          (TS_W),
    .TRAVEL_CYCLES (TRAVEL),
    .PULSE_CYCLES  (PULSE),
    .GAP_CYCLES    (GAP),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .grade_valid  (grade_valid),
    .grade        (grade),
    .grade_ready  (grade_ready),
    .gate_baja    (gate_baja),
    .gate_media   (gate_media),
    .gate_alta    (gate_alta),
    .gate_rechazo (gate_rechazo),
    .busy         (busy),
    .overflow     (overflow),
    .cnt_baja     (cnt_baja),
    .cnt_media    (cnt_media),
    .cnt_alta     (cnt_alta)
  );

  typedef struct {
    int grade;
    int acc;
  } bean_t;

  // Model: queue of beans in transit plus the schedule of the last pop.
  bean_t q[$];
  int    cyc;
  int    next_idle;
  int    last_pop;
  int    last_grade;
  bit    have_pop;
  int    mcnt [3];
  bit    movf;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc       = 0;
    next_idle = 0;
    have_pop  = 1'b0;
    last_pop  = 0;
    last_grade = 0;
    mcnt      = '{default: 0};
    movf      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gates"}, {gate_rechazo, gate_alta, gate_media, gate_baja}, 0);
    chk({tag, "_ready"}, grade_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_cnt"}, {cnt_alta, cnt_media, cnt_baja}, 0);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input bit v, input int g);
    bit ready_e, busy_e, firing;
    int gates_e;
    grade_valid = v;
    grade       = g[1:0];
    @(negedge clk);
    ready_e = (q.size() < DEPTH);
    firing  = have_pop && (cyc >= last_pop + 1) && (cyc <= last_pop + PULSE);
    busy_e  = (q.size() > 0) || (have_pop && (cyc >= last_pop + 1) && (cyc <= last_pop + PULSE + GAP));
    gates_e = firing ? (1 << last_grade) : 0;
    chk("gates", {gate_rechazo, gate_alta, gate_media, gate_baja}, gates_e);
    chk("ready", grade_ready, ready_e);
    chk("busy", busy, busy_e);
    chk("overflow", overflow, movf);
    chk("cnt_baja", cnt_baja, mcnt[0]);
    chk("cnt_media", cnt_media, mcnt[1]);
    chk("cnt_alta", cnt_alta, mcnt[2]);
    if (q.size() > 0 && (cyc - q[0].acc) >= TRAVEL && cyc >= next_idle) begin
      have_pop   = 1'b1;
      last_pop   = cyc;
      last_grade = q[0].grade;
      next_idle  = cyc + PULSE + GAP + 1;
      if (last_grade < 3 && mcnt[last_grade] < CNT_MAX) mcnt[last_grade]++;
      void'(q.pop_front());
    end
    if (v) begin
      if (ready_e) q.push_back('{grade: g, acc: cyc});
      else movf = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    grade_valid = 1'b0;
    grade       = 2'd0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    do_reset();

    // Single alta bean accepted at cycle 10.
    repeat (10) step(0, 0);
    step(1, 2);
    repeat (30) step(0, 0);

    // Three grades on consecutive cycles, fired back to back.
    do_reset();
    repeat (10) step(0, 0);
    step(1, 0);
    step(1, 1);
    step(1, 2);
    repeat (45) step(0, 0);

    // Valid held six cycles with no drain: fills, then drops and flags overflow.
    for (int i = 0; i < 6; i++) step(1, i % 4);
    repeat (60) step(0, 0);
    chk("ovf_sticky", overflow, 1);
    chk("busy_drained", busy, 0);

    // Reject bean: pulses gate_rechazo, counters untouched.
    step(1, 3);
    repeat (30) step(0, 0);

    // Reset during the second FIRE cycle clears everything immediately.
    step(1, 1);
    step(1, 2);
    for (int i = 0; i < 100 && !(have_pop && cyc == last_pop + 2); i++) step(0, 0);
    chk("reach_fire2", {31'd0, have_pop && cyc == last_pop + 2}, 1);
    chk("fire2_gate", gate_media, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midpulse");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (40) step(0, 0);

    // Timestamp wrap: accept at ts=250, pop at ts=14.
    do_reset();
    while (cyc < 250) step(0, 0);
    step(1, 1);
    repeat (40) step(0, 0);

    // Random traffic, varying load so both gaps and overflow occur.
    for (int i = 0; i < 1500; i++) begin
      int lim;
      lim = (i < 750) ? 6 : 2;
      step($urandom_range(0, lim) == 0, int'($urandom_range(0, 3)));
    end
    repeat (60) step(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
